// File: rtl/efpga_cfg_pkg.sv
// Shared definitions for the eFPGA configuration loader: register offsets,
// CTRL/STATUS bit positions and the loader FSM state encoding.
package efpga_cfg_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_DATA   = 4'h8;
    localparam logic [3:0] OFF_CHK    = 4'hC;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_CRC   = 3;
    localparam int STAT_FULL  = 4;
    localparam int STAT_EMPTY = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE,
        S_DONE
    } cfg_state_e;

endpackage

// File: rtl/efpga_cfg_fifo.sv
// Synchronous frame FIFO with push/pop/flush and occupancy count.
// Pushes while full and pops while empty are ignored; flush has priority.
module efpga_cfg_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/efpga_cfg_loader.sv
// Wishbone-slave bitstream loader: buffers frames in a FIFO and replays them onto
// the fabric frame port. Optional checksum check enabled by EFPGA_CFG_CHECKSUM_EN.
module efpga_cfg_loader
    import efpga_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FRAME_BITS = 32,
    parameter int          NUM_FRAMES = 20,
    parameter int          ADDR_W     = 5,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [ADDR_W-1:0]     cfg_frame_addr,
    output logic [FRAME_BITS-1:0] cfg_frame_data,
    output logic                  cfg_frame_strobe,
    output logic                  cfg_done
);

    localparam int CNT_W  = $clog2(NUM_FRAMES + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    cfg_state_e              state_q, state_d;
    logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [FRAME_BITS-1:0]   data_q, data_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic                    crc_q, crc_d;
    logic                    ack_q;
    logic [31:0]             dat_q;

    logic                    hit, req, wr_req, rd_req;
    logic [3:0]              offset;
    logic                    start_req, abort_req, start_ok;
    logic                    fifo_push, fifo_pop;
    logic [FRAME_BITS-1:0]   fifo_dout;
    logic                    fifo_full, fifo_empty;
    logic [FCNT_W-1:0]       fifo_count;
    logic                    sum_ok;
    logic [31:0]             status, rdata;
    logic                    unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // A new request is refused while ack is high, which yields the ack-every-other-cycle rhythm.
    assign hit       = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req       = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
    assign wr_req    = req & wbs_we_i;
    assign rd_req    = req & ~wbs_we_i;
    assign offset    = wbs_adr_i[3:0];
    assign abort_req = wr_req && (offset == OFF_CTRL) && wbs_dat_i[CTRL_ABORT];
    assign start_req = wr_req && (offset == OFF_CTRL) && wbs_dat_i[CTRL_START] && !wbs_dat_i[CTRL_ABORT];
    assign start_ok  = start_req && (state_q == S_IDLE);
    assign fifo_push = wr_req && (offset == OFF_DATA);

    efpga_cfg_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (abort_req),
        .din_i   (wbs_dat_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef EFPGA_CFG_CHECKSUM_EN
    logic [31:0] sum_q, exp_q;
    logic        chk_wr;

    assign chk_wr = wr_req && (offset == OFF_CHK);
    assign sum_ok = (sum_q == exp_q);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sum_q <= '0;
            exp_q <= '0;
        end else begin
            if (start_ok)      sum_q <= '0;
            else if (fifo_pop) sum_q <= sum_q + 32'(fifo_dout);
            if (chk_wr)        exp_q <= wbs_dat_i;
        end
    end
`else
    assign sum_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = done_q;
        crc_d       = crc_q;
        ovf_d       = ovf_q | (fifo_push & fifo_full);
        fifo_pop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d     = S_LOAD;
                    frame_cnt_d = '0;
                    done_d      = 1'b0;
                    ovf_d       = 1'b0;
                    crc_d       = 1'b0;
                end
            end
            S_LOAD: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = frame_cnt_q[ADDR_W-1:0];
                    data_d   = fifo_dout;
                    state_d  = S_STROBE;
                end
            end
            S_STROBE: begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                state_d     = (frame_cnt_q == CNT_W'(NUM_FRAMES - 1)) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done_d  = sum_ok;
                crc_d   = ~sum_ok;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_req) begin
            state_d     = S_IDLE;
            fifo_pop    = 1'b0;
            frame_cnt_d = '0;
            done_d      = 1'b0;
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_BUSY]     = (state_q != S_IDLE);
        status[STAT_DONE]     = done_q;
        status[STAT_OVF]      = ovf_q;
        status[STAT_CRC]      = crc_q;
        status[STAT_FULL]     = fifo_full;
        status[STAT_EMPTY]    = fifo_empty;
        status[15:8]          = 8'(fifo_count);
        status[23:16]         = 8'(frame_cnt_q);
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_STATUS: rdata = status;
`ifdef EFPGA_CFG_CHECKSUM_EN
            OFF_CHK:    rdata = sum_q;
`endif
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            crc_q       <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            crc_q       <= crc_d;
            ack_q       <= req;
            dat_q       <= rd_req ? rdata : '0;
        end
    end

    assign wbs_ack_o        = ack_q;
    assign wbs_dat_o        = dat_q;
    assign cfg_frame_addr   = addr_q;
    assign cfg_frame_data   = data_q;
    assign cfg_frame_strobe = (state_q == S_STROBE);
    assign cfg_done         = done_q;

endmodule

// File: tb/tb_efpga_cfg_loader.sv
// Directed bench for efpga_cfg_loader; expectations follow EFPGA_CFG_CHECKSUM_EN when defined.
module tb_efpga_cfg_loader;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_DATA = BASE + 32'h8;
    localparam logic [31:0] A_CHK  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [4:0]  f_addr;
    logic [31:0] f_data;
    logic        f_strobe, f_done;

    int compared = 0;
    int mismatched = 0;
    int strobe_cnt = 0;
    logic [4:0]  s_addr[$];
    logic [31:0] s_data[$];

    efpga_cfg_loader dut (
        .wb_clk_i         (clk),
        .wb_rst_ni        (rst_n),
        .wbs_stb_i        (stb),
        .wbs_cyc_i        (cyc),
        .wbs_we_i         (we),
        .wbs_sel_i        (sel),
        .wbs_adr_i        (adr),
        .wbs_dat_i        (wdat),
        .wbs_ack_o        (ack),
        .wbs_dat_o        (rdat),
        .cfg_frame_addr   (f_addr),
        .cfg_frame_data   (f_data),
        .cfg_frame_strobe (f_strobe),
        .cfg_done         (f_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (f_strobe) begin
            s_addr.push_back(f_addr);
            s_data.push_back(f_data);
            strobe_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output logic ack_seen, output logic [31:0] rd);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
        @(posedge clk); #1;
        ack_seen = ack; rd = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic        k;
        logic [31:0] r;
        wb_access(1'b1, a, d, k, r);
        chk($sformatf("wr_ack@%h", a), {31'd0, k}, 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        logic k;
        wb_access(1'b0, a, 32'h0, k, d);
        chk($sformatf("rd_ack@%h", a), {31'd0, k}, 32'd1);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk("strobe_wait", strobe_cnt, target);
    endtask

    task automatic run_full(input logic [31:0] chk_val);
        int base = strobe_cnt;
        wr(A_CHK, chk_val);
        for (int i = 0; i < 8; i++) wr(A_DATA, 32'h1000 + i);
        wr(A_CTRL, 32'h1);
        for (int i = 8; i < 20; i++) wr(A_DATA, 32'h1000 + i);
        wait_strobes(base + 20, 400);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("frame%0d_addr", i), {27'd0, s_addr[base + i]}, i);
            chk($sformatf("frame%0d_data", i), s_data[base + i], 32'h1000 + i);
        end
    endtask

    initial begin
        logic        k;
        logic [31:0] r, sum;
        int          base;

        sum = '0;
        for (int i = 0; i < 20; i++) sum = sum + 32'h1000 + i;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_addr", {27'd0, f_addr}, 0);
        chk("rst_data", f_data, 0);
        chk("rst_strobe", {31'd0, f_strobe}, 0);
        chk("rst_done", {31'd0, f_done}, 0);
        rst_n = 1'b1;

        rd(A_STAT, r);  chk("status_idle", r, 32'h0000_0020);
        rd(A_CTRL, r);  chk("ctrl_read", r, 0);
        rd(A_DATA, r);  chk("data_read", r, 0);
        wb_access(1'b1, BASE + 32'h10, 32'h1, k, r);
        chk("undecoded_wr_ack", {31'd0, k}, 0);
        wb_access(1'b0, 32'h3000_1004, 32'h0, k, r);
        chk("undecoded_rd_ack", {31'd0, k}, 0);

        // Full bitstream with matching checksum
        run_full(sum);
        chk("runA_cfg_done", {31'd0, f_done}, 1);
        rd(A_STAT, r);  chk("runA_status", r, 32'h0014_0022);
        rd(A_CHK, r);
`ifdef EFPGA_CFG_CHECKSUM_EN
        chk("runA_chk_read", r, sum);
`else
        chk("runA_chk_read", r, 0);
`endif

        // Overflow: 9 pushes into an 8-deep FIFO, every push acked
        for (int i = 0; i < 9; i++) wr(A_DATA, 32'h5000 + i);
        rd(A_STAT, r);  chk("ovf_status", r, 32'h0014_0816);

        // start+abort together: abort wins, FIFO flushed
        wr(A_CTRL, 32'h3);
        rd(A_STAT, r);  chk("startabort_status", r & 32'h00FF_FF33, 32'h0000_0020);
        chk("startabort_cfg_done", {31'd0, f_done}, 0);

        // Start with an empty FIFO; frames follow slow pushes; start while busy ignored
        base = strobe_cnt;
        wr(A_CTRL, 32'h1);
        rd(A_STAT, r);  chk("slow_status_busy", r, 32'h0000_0021);
        repeat (10) @(posedge clk);
        #1;
        chk("slow_no_strobe", strobe_cnt, base);
        for (int i = 0; i < 3; i++) begin
            wr(A_DATA, 32'h2000 + i);
            wait_strobes(base + i + 1, 20);
            chk($sformatf("slow%0d_addr", i), {27'd0, s_addr[base + i]}, i);
            chk($sformatf("slow%0d_data", i), s_data[base + i], 32'h2000 + i);
            if (i == 0) wr(A_CTRL, 32'h1);
        end
        wr(A_CTRL, 32'h2);

        // Abort right after the 5th strobe with frames still queued
        for (int i = 0; i < 8; i++) wr(A_DATA, 32'h3000 + i);
        base = strobe_cnt;
        wr(A_CTRL, 32'h1);
        wait_strobes(base + 5, 100);
        wr(A_CTRL, 32'h2);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_strobes", strobe_cnt, base + 5);
        chk("abort_cfg_done", {31'd0, f_done}, 0);
        rd(A_STAT, r);  chk("abort_status", r, 32'h0000_0020);

        // Restart loads from frame address 0
        base = strobe_cnt;
        wr(A_DATA, 32'h4000);
        wr(A_DATA, 32'h4001);
        wr(A_CTRL, 32'h1);
        wait_strobes(base + 2, 40);
        chk("restart0_addr", {27'd0, s_addr[base]}, 0);
        chk("restart0_data", s_data[base], 32'h4000);
        chk("restart1_addr", {27'd0, s_addr[base + 1]}, 1);

        // Asynchronous reset while waiting in LOAD
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_addr", {27'd0, f_addr}, 0);
        chk("arst_data", f_data, 0);
        chk("arst_strobe", {31'd0, f_strobe}, 0);
        chk("arst_done", {31'd0, f_done}, 0);
        chk("arst_ack", {31'd0, ack}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_STAT, r);  chk("arst_status", r, 32'h0000_0020);

        // Full bitstream with a wrong checksum
        run_full(sum + 32'h1);
        rd(A_STAT, r);
`ifdef EFPGA_CFG_CHECKSUM_EN
        chk("runB_cfg_done", {31'd0, f_done}, 0);
        chk("runB_status", r, 32'h0014_0028);
`else
        chk("runB_cfg_done", {31'd0, f_done}, 1);
        chk("runB_status", r, 32'h0014_0022);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
